// File: rtl/alarm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_pkg : shared state encoding and default timing for alarm_ringer|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_e;

    localparam int c_def_ring_timeout_s = 60;
    localparam int c_def_snooze_s       = 300;
    localparam int c_def_max_snooze     = 3;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_ringer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_ringer : turns the raw alarm match into buzzer/snooze/missed    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = c_def_ring_timeout_s,
    parameter int SNOOZE_S       = c_def_snooze_s,
    parameter int MAX_SNOOZE     = c_def_max_snooze
) (
    input  logic                                clk_1Hz,
    input  logic                                rst,
    input  logic                                alarm_en,
    input  logic                                alarm_trigger,
    input  logic                                snooze_btn,
    input  logic                                stop_btn,
    output logic                                buzzer,
    output logic                                ringing,
    output logic                                snoozed,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_cnt,
    output logic [$clog2(SNOOZE_S+1)-1:0]       snooze_left,
    output logic                                missed
);

    localparam int c_rt_w   = $clog2(RING_TIMEOUT_S);
    localparam int c_cnt_w  = $clog2(MAX_SNOOZE + 1);
    localparam int c_left_w = $clog2(SNOOZE_S + 1);

    localparam logic [c_rt_w-1:0]   c_ring_last = c_rt_w'(RING_TIMEOUT_S - 1);
    localparam logic [c_rt_w-1:0]   c_rt_one    = c_rt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_snz_max   = c_cnt_w'(MAX_SNOOZE);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_left_w-1:0] c_snz_len   = c_left_w'(SNOOZE_S);
    localparam logic [c_left_w-1:0] c_left_one  = c_left_w'(1);

    alarm_state_e        state_q,       state_d;
    logic                trig_q,        trig_d;
    logic [c_rt_w-1:0]   ring_timer_q,  ring_timer_d;
    logic                beep_phase_q,  beep_phase_d;
    logic                buzzer_q,      buzzer_d;
    logic                ringing_q,     ringing_d;
    logic                snoozed_q,     snoozed_d;
    logic [c_cnt_w-1:0]  snooze_cnt_q,  snooze_cnt_d;
    logic [c_left_w-1:0] snooze_left_q, snooze_left_d;
    logic                missed_q,      missed_d;

    logic                w_trig_edge;

    // A trigger held high for the whole matching minute fires only once.
    assign w_trig_edge = alarm_trigger & ~trig_q;

    always_comb begin
        state_d       = state_q;
        trig_d        = alarm_trigger;
        ring_timer_d  = ring_timer_q;
        beep_phase_d  = beep_phase_q;
        buzzer_d      = buzzer_q;
        snooze_cnt_d  = snooze_cnt_q;
        snooze_left_d = snooze_left_q;
        missed_d      = missed_q;

        if (!alarm_en) begin
            // Disarming silences everything but leaves the missed flag visible.
            state_d       = IDLE;
            ring_timer_d  = '0;
            beep_phase_d  = 1'b0;
            buzzer_d      = 1'b0;
            snooze_cnt_d  = '0;
            snooze_left_d = '0;
        end else if (stop_btn) begin
            state_d       = IDLE;
            ring_timer_d  = '0;
            beep_phase_d  = 1'b0;
            buzzer_d      = 1'b0;
            snooze_cnt_d  = '0;
            snooze_left_d = '0;
            missed_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_trig_edge) begin
                        state_d       = RINGING;
                        ring_timer_d  = '0;
                        beep_phase_d  = 1'b1;
                        buzzer_d      = 1'b1;
                        snooze_cnt_d  = '0;
                        snooze_left_d = '0;
                        missed_d      = 1'b0;
                    end
                end
                RINGING: begin
                    if (ring_timer_q == c_ring_last) begin
                        state_d      = IDLE;
                        ring_timer_d = '0;
                        beep_phase_d = 1'b0;
                        buzzer_d     = 1'b0;
                        missed_d     = 1'b1;
                    end else if (snooze_btn && (snooze_cnt_q < c_snz_max)) begin
                        state_d       = SNOOZE;
                        ring_timer_d  = '0;
                        beep_phase_d  = 1'b0;
                        buzzer_d      = 1'b0;
                        snooze_cnt_d  = snooze_cnt_q + c_cnt_one;
                        snooze_left_d = c_snz_len;
                    end else begin
                        beep_phase_d = ~beep_phase_q;
                        buzzer_d     = ~beep_phase_q;
                        ring_timer_d = ring_timer_q + c_rt_one;
                    end
                end
                SNOOZE: begin
                    if (snooze_left_q == c_left_one) begin
                        state_d       = RINGING;
                        snooze_left_d = '0;
                        ring_timer_d  = '0;
                        beep_phase_d  = 1'b1;
                        buzzer_d      = 1'b1;
                    end else if (snooze_left_q != '0) begin
                        snooze_left_d = snooze_left_q - c_left_one;
                    end
                end
                default: begin
                    state_d       = IDLE;
                    ring_timer_d  = '0;
                    beep_phase_d  = 1'b0;
                    buzzer_d      = 1'b0;
                    snooze_cnt_d  = '0;
                    snooze_left_d = '0;
                end
            endcase
        end

        ringing_d = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            trig_q        <= 1'b0;
            ring_timer_q  <= '0;
            beep_phase_q  <= 1'b0;
            buzzer_q      <= 1'b0;
            ringing_q     <= 1'b0;
            snoozed_q     <= 1'b0;
            snooze_cnt_q  <= '0;
            snooze_left_q <= '0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_q        <= trig_d;
            ring_timer_q  <= ring_timer_d;
            beep_phase_q  <= beep_phase_d;
            buzzer_q      <= buzzer_d;
            ringing_q     <= ringing_d;
            snoozed_q     <= snoozed_d;
            snooze_cnt_q  <= snooze_cnt_d;
            snooze_left_q <= snooze_left_d;
            missed_q      <= missed_d;
        end
    end

    assign buzzer      = buzzer_q;
    assign ringing     = ringing_q;
    assign snoozed     = snoozed_q;
    assign snooze_cnt  = snooze_cnt_q;
    assign snooze_left = snooze_left_q;
    assign missed      = missed_q;

endmodule : alarm_ringer
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alarm_ringer : scoreboard bench for alarm_ringer (6 s / 4 s / 2)   |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_alarm_ringer;

    localparam int c_ring_timeout_s = 6;
    localparam int c_snooze_s       = 4;
    localparam int c_max_snooze     = 2;

    logic       clk_1Hz;
    logic       rst;
    logic       alarm_en;
    logic       alarm_trigger;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozed;
    logic [1:0] snooze_cnt;
    logic [2:0] snooze_left;
    logic       missed;

    typedef struct {
        string tag;
        bit    bz;
        bit    rg;
        bit    sn;
        bit    miss;
        int    cnt;
        int    left;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alarm_ringer #(
        .RING_TIMEOUT_S (c_ring_timeout_s),
        .SNOOZE_S       (c_snooze_s),
        .MAX_SNOOZE     (c_max_snooze)
    ) u_dut (
        .clk_1Hz       (clk_1Hz),
        .rst           (rst),
        .alarm_en      (alarm_en),
        .alarm_trigger (alarm_trigger),
        .snooze_btn    (snooze_btn),
        .stop_btn      (stop_btn),
        .buzzer        (buzzer),
        .ringing       (ringing),
        .snoozed       (snoozed),
        .snooze_cnt    (snooze_cnt),
        .snooze_left   (snooze_left),
        .missed        (missed)
    );

    initial begin
        clk_1Hz = 1'b0;
        forever #5 clk_1Hz = ~clk_1Hz;
    end

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input logic t, input logic e, input logic s, input logic p);
        @(negedge clk_1Hz);
        alarm_trigger = t;
        alarm_en      = e;
        snooze_btn    = s;
        stop_btn      = p;
    endtask

    // cnt/left of -1 mean "not checked on this sample".
    task automatic exp_push(input string tag, input bit bz, input bit rg, input bit sn,
                            input bit miss, input int cnt, input int left);
        exp_t e;
        e.tag  = tag;
        e.bz   = bz;
        e.rg   = rg;
        e.sn   = sn;
        e.miss = miss;
        e.cnt  = cnt;
        e.left = left;
        sb_q.push_back(e);
    endtask

    // Monitor: each clock edge (or async reset assertion) presents a fresh output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1Hz or posedge rst);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".buzzer"},  32'(buzzer),  int'(e.bz));
                check({e.tag, ".ringing"}, 32'(ringing), int'(e.rg));
                check({e.tag, ".snoozed"}, 32'(snoozed), int'(e.sn));
                check({e.tag, ".missed"},  32'(missed),  int'(e.miss));
                if (e.cnt >= 0)  check({e.tag, ".snooze_cnt"},  32'(snooze_cnt),  e.cnt);
                if (e.left >= 0) check({e.tag, ".snooze_left"}, 32'(snooze_left), e.left);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 50000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        alarm_en      = 1'b0;
        alarm_trigger = 1'b0;
        snooze_btn    = 1'b0;
        stop_btn      = 1'b0;
        rst           = 1'b0;

        #1;
        exp_push("reset_async", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 1, 0, 0); exp_push("reset_held", 0, 0, 0, 0, 0, 0);
        @(negedge clk_1Hz);
        rst = 1'b0;

        // Unattended ring: trigger held for 10 edges, fires once, times out.
        cyc(1, 1, 0, 0); exp_push("to_e1", 1, 1, 0, 0, 0, 0);
        for (int i = 2; i <= 6; i++) begin
            cyc(1, 1, 0, 0); exp_push($sformatf("to_e%0d", i), bit'(i % 2), 1, 0, 0, -1, -1);
        end
        cyc(1, 1, 0, 0); exp_push("to_idle", 0, 0, 0, 1, -1, 0);
        for (int i = 8; i <= 10; i++) begin
            cyc(1, 1, 0, 0); exp_push($sformatf("to_hold%0d", i), 0, 0, 0, 1, -1, -1);
        end
        cyc(0, 1, 0, 0); exp_push("to_low", 0, 0, 0, 1, -1, -1);

        // Stop on the 3rd edge; entry to RINGING clears missed.
        cyc(1, 1, 0, 0); exp_push("stop_e1", 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("stop_e2", 0, 1, 0, 0, 0, -1);
        cyc(1, 1, 0, 1); exp_push("stop_e3", 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0); exp_push("stop_after", 0, 0, 0, 0, 0, 0);

        // Snooze on the 2nd edge, wake after 4 s.
        cyc(1, 1, 0, 0); exp_push("snz_e1", 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0); exp_push("snz_e2", 0, 0, 1, 0, 1, 4);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 0); exp_push($sformatf("snz_l%0d", 4 - i), 0, 0, 1, 0, 1, 4 - i);
        end
        cyc(0, 1, 0, 0); exp_push("snz_wake", 1, 1, 0, 0, 1, 0);

        // Second snooze; re-trigger and snooze button inside SNOOZE are ignored.
        cyc(0, 1, 1, 0); exp_push("snz2", 0, 0, 1, 0, 2, 4);
        cyc(1, 1, 0, 0); exp_push("snz2_retrig", 0, 0, 1, 0, 2, 3);
        cyc(1, 1, 1, 0); exp_push("snz2_btn", 0, 0, 1, 0, 2, 2);
        cyc(0, 1, 0, 0); exp_push("snz2_l1", 0, 0, 1, 0, 2, 1);
        cyc(0, 1, 0, 0); exp_push("snz2_wake", 1, 1, 0, 0, 2, 0);

        // Third snooze refused; re-trigger while ringing ignored; runs to timeout.
        cyc(0, 1, 1, 0); exp_push("snz3_ignored", 0, 1, 0, 0, 2, 0);
        cyc(1, 1, 0, 0); exp_push("ring_retrig", 1, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0); exp_push("ring_t3", 0, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0); exp_push("ring_t4", 1, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0); exp_push("ring_t5", 0, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0); exp_push("snz_timeout", 0, 0, 0, 1, -1, 0);
        cyc(0, 1, 0, 1); exp_push("stop_clears_missed", 0, 0, 0, 0, 0, 0);

        // Stop and snooze on the same ringing edge: stop wins.
        cyc(1, 1, 0, 0); exp_push("both_e1", 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1); exp_push("both_e2", 0, 0, 0, 0, 0, 0);

        // Disarm in the middle of a snooze.
        cyc(1, 1, 0, 0); exp_push("en_e1", 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0); exp_push("en_snz", 0, 0, 1, 0, 1, 4);
        cyc(0, 1, 0, 0); exp_push("en_l3", 0, 0, 1, 0, 1, 3);
        cyc(0, 0, 0, 0); exp_push("en_drop", 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0); exp_push("en_low_trig", 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("en_rearm_held", 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0); exp_push("en_idle", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset between edges while ringing.
        cyc(1, 1, 0, 0); exp_push("ar_e1", 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("ar_e2", 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("ar_e3", 1, 1, 0, 0, 0, 0);
        @(negedge clk_1Hz);
        alarm_trigger = 1'b0;
        #2;
        exp_push("ar_async", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cyc(0, 1, 0, 0); exp_push("ar_idle", 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("ar_new_e1", 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0); exp_push("ar_new_e2", 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1); exp_push("ar_stop", 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk_1Hz);
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_alarm_ringer
`default_nettype wire

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Alarm sequencer directly downstream of the time-counter stage.
- Consumes the raw alarm_trigger match and turns it into a user-facing alarm: an intermittent buzzer, a bounded ring time, a limited number of snoozes, and a missed-alarm flag.
- Runs entirely in the 1 Hz domain.
- Its outputs drive the buzzer pin and the status indicators or seven-segment logic at top level.

Parameters:
- RING_TIMEOUT_S, 60, seconds the alarm rings before it gives up unattended (≥2).
- SNOOZE_S, 300, snooze length in seconds (≥2).
- MAX_SNOOZE, 3, maximum snoozes per alarm event (≥1).

Ports:
- clk_1Hz  input  1  1 Hz system tick clock.
- rst  input  1  asynchronous, active-high reset.
- alarm_en  input  1  alarm armed; low forces IDLE.
- alarm_trigger  input  1  level from the time counters, high while current time matches alarm time.
- snooze_btn  input  1  snooze request, level, sampled each clk_1Hz edge.
- stop_btn  input  1  dismiss request, level, sampled each clk_1Hz edge.
- buzzer  output  1  buzzer drive, 1 s on / 1 s off while ringing.
- ringing  output  1  high in RINGING.
- snoozed  output  1  high in SNOOZE.
- snooze_cnt  output  $clog2(MAX_SNOOZE+1)  snoozes used in the current event.
- snooze_left  output  $clog2(SNOOZE_S+1)  seconds remaining in the snooze.
- missed  output  1  sticky flag: an alarm timed out unattended.

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clock is clk_1Hz.
- All outputs are registered. Reset values: buzzer=0, ringing=0, snoozed=0, snooze_cnt=0, snooze_left=0, missed=0. State resets to IDLE.
- Internal state: trig_q (previous alarm_trigger), ring_timer, beep_phase; all reset to 0.
- trig_q <= alarm_trigger every edge.
- Trigger edge: trig_edge = alarm_trigger & ~trig_q. Only the rising edge matters; a trigger held high for a whole minute fires once.
- States: IDLE, RINGING, SNOOZE.
- Priority within one edge, highest first: alarm_en low > stop_btn > timeout/expiry > snooze_btn.
- IDLE:
  - On trig_edge & alarm_en: go to RINGING; ring_timer=0, beep_phase=1, buzzer=1, snooze_cnt=0.
  - Latency: buzzer is high after the first edge at which alarm_trigger is sampled high.
- RINGING:
  - beep_phase toggles each edge; buzzer=beep_phase.
  - ring_timer increments each edge.
  - stop_btn: go to IDLE; missed=0, snooze_cnt=0.
  - ring_timer==RING_TIMEOUT_S-1 and no stop: go to IDLE; missed=1.
  - snooze_btn with snooze_cnt<MAX_SNOOZE: go to SNOOZE; snooze_left=SNOOZE_S, snooze_cnt+1, buzzer=0.
  - snooze_btn with snooze_cnt==MAX_SNOOZE: ignored; keep ringing.
  - stop_btn and snooze_btn together: stop wins.
- SNOOZE:
  - snooze_left decrements each edge.
  - When snooze_left==1: go to RINGING; snooze_left=0, ring_timer=0, beep_phase=1, buzzer=1.
  - stop_btn: go to IDLE; snooze_cnt=0, snooze_left=0.
  - snooze_btn: ignored (no re-arm).
- Re-triggers: a trig_edge during RINGING or SNOOZE is ignored, with no restart and no error.
- alarm_en low in any state: go to IDLE next edge; buzzer=0, snooze_cnt=0, snooze_left=0; missed unchanged.
- missed: set only on timeout. Cleared by stop_btn in any state, or on entry to RINGING from IDLE.
- Outputs are a function of state: ringing=(state==RINGING); snoozed=(state==SNOOZE); buzzer is 0 outside RINGING.
- Reset mid-ring or mid-snooze: immediate return to all reset values; no resume.
- Counter widths are sized from parameters. Counters never wrap; terminal compares bound them.

Decomposition:
- Shared package alarm_pkg: state typedef (IDLE, RINGING, SNOOZE) and default constants for RING_TIMEOUT_S, SNOOZE_S, MAX_SNOOZE.
- Single flat module with no sub-module; edge detect and timers are a few lines each.

Test Plan (bench overrides RING_TIMEOUT_S=6, SNOOZE_S=4, MAX_SNOOZE=2):
- Reset, alarm_en=1, then alarm_trigger high for 10 edges -> ringing=1 from the first edge; buzzer pattern 1,0,1,0,1,0; back to IDLE after the 6th edge with missed=1; no second ring while the trigger is still high.
- Trigger, then stop_btn on the 3rd edge -> IDLE on that edge; buzzer=0; missed=0; snooze_cnt=0.
- Trigger, then snooze on the 2nd edge -> snoozed=1, snooze_left steps 4,3,2,1; ringing=1 with buzzer=1 on the 4th edge after; snooze_cnt=1.
- Snooze twice, then snooze a 3rd time -> the 3rd is ignored, snooze_cnt stays 2, rings to timeout with missed=1; stop_btn afterwards clears missed.
- stop_btn and snooze_btn in the same ringing edge -> IDLE. alarm_en dropped mid-SNOOZE -> IDLE next edge with snooze_left=0.
- Async rst pulse between clock edges during RINGING -> all outputs 0 immediately; a new trigger edge after reset rings normally.
